// File: rtl/delay_timer.sv
// One-shot delay timer counting us/ms tick strobes with start/busy/done.
// Optional periodic reload mode is enabled by DELAY_TIMER_RELOAD_EN.
module delay_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             us_tck,
  input  logic             ms_tck,
  input  logic             start,
  input  logic             unit_sel,
  input  logic [CNT_W-1:0] delay_val,
  input  logic             abort,
`ifdef DELAY_TIMER_RELOAD_EN
  input  logic             periodic,
`endif
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic             unit_q, unit_d;
  logic             busy_d, done_d;
  logic [CNT_W-1:0] rem_d;
  logic             tck;

`ifdef DELAY_TIMER_RELOAD_EN
  logic             per_q, per_d;
  logic [CNT_W-1:0] reload_q, reload_d;
`endif

  assign tck = unit_q ? ms_tck : us_tck;

  always_comb begin
    state_d = state_q;
    unit_d  = unit_q;
    busy_d  = busy;
    done_d  = 1'b0;
    rem_d   = remaining;
`ifdef DELAY_TIMER_RELOAD_EN
    per_d    = per_q;
    reload_d = reload_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          unit_d = unit_sel;
`ifdef DELAY_TIMER_RELOAD_EN
          per_d    = periodic;
          reload_d = delay_val;
`endif
          if (delay_val != '0) begin
            state_d = COUNT;
            busy_d  = 1'b1;
            rem_d   = delay_val;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      COUNT: begin
        // abort beats a coincident final tick
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          rem_d   = '0;
        end else if (tck) begin
          if (remaining <= CNT_W'(1)) begin
            done_d = 1'b1;
            rem_d  = '0;
`ifdef DELAY_TIMER_RELOAD_EN
            if (per_q) begin
              rem_d = reload_q;
            end else begin
              state_d = DONE;
              busy_d  = 1'b0;
            end
`else
            state_d = DONE;
            busy_d  = 1'b0;
`endif
          end else begin
            rem_d = remaining - CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        rem_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      unit_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
`ifdef DELAY_TIMER_RELOAD_EN
      per_q    <= 1'b0;
      reload_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      unit_q    <= unit_d;
      busy      <= busy_d;
      done      <= done_d;
      remaining <= rem_d;
`ifdef DELAY_TIMER_RELOAD_EN
      per_q    <= per_d;
      reload_q <= reload_d;
`endif
    end
  end

endmodule
